// File: rtl/call_scheduler_pkg.sv
// Shared floor encodings, FSM state type and helpers for the cabin call scheduler.
package call_scheduler_pkg;

    localparam int unsigned FLOOR_W = 2;
    localparam int unsigned NUM_FLOORS = 3;

    localparam logic [FLOOR_W-1:0] FLOOR1    = 2'b00;
    localparam logic [FLOOR_W-1:0] FLOOR2    = 2'b01;
    localparam logic [FLOOR_W-1:0] FLOOR3    = 2'b10;
    localparam logic [FLOOR_W-1:0] FLOOR_BAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISPATCH = 3'd1,
        ST_TRAVEL   = 3'd2,
        ST_DWELL    = 3'd3,
        ST_HALT     = 3'd4
    } state_e;

    // One-hot floor mask; the illegal encoding maps to an empty mask.
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        return NUM_FLOORS'(1) << f;
    endfunction

endpackage

// File: rtl/call_scheduler_if.sv
// Goal/door handshake between the call scheduler and the movement datapath.
interface call_scheduler_if;
    import call_scheduler_pkg::*;

    logic [FLOOR_W-1:0] cur_floor;
    logic               moving;
    logic [FLOOR_W-1:0] goal_floor;
    logic               goal_valid;
    logic               dir_up;
    logic               door_open;

    modport master (
        input  cur_floor,
        input  moving,
        output goal_floor,
        output goal_valid,
        output dir_up,
        output door_open
    );

    modport slave (
        output cur_floor,
        output moving,
        input  goal_floor,
        input  goal_valid,
        input  dir_up,
        input  door_open
    );

endinterface

// File: rtl/call_scheduler_scan_select.sv
// SCAN goal picker: current floor first, then nearest ahead in the sweep, else nearest behind.
module call_scheduler_scan_select
    import call_scheduler_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  dir_up,
    output logic [FLOOR_W-1:0]    goal,
    output logic                  has_goal
);

    logic                above_ok;
    logic [FLOOR_W-1:0]  above_goal;
    logic                below_ok;
    logic [FLOOR_W-1:0]  below_goal;
    logic                here_ok;

    // Nearest pending floor strictly above and strictly below the car.
    always_comb begin
        above_ok   = 1'b0;
        above_goal = cur_floor;
        below_ok   = 1'b0;
        below_goal = cur_floor;
        here_ok    = |(pending & floor_onehot(cur_floor));

        case (cur_floor)
            FLOOR1: begin
                if (pending[1]) begin
                    above_ok   = 1'b1;
                    above_goal = FLOOR2;
                end else if (pending[2]) begin
                    above_ok   = 1'b1;
                    above_goal = FLOOR3;
                end
            end
            FLOOR2: begin
                if (pending[2]) begin
                    above_ok   = 1'b1;
                    above_goal = FLOOR3;
                end
                if (pending[0]) begin
                    below_ok   = 1'b1;
                    below_goal = FLOOR1;
                end
            end
            FLOOR3: begin
                if (pending[1]) begin
                    below_ok   = 1'b1;
                    below_goal = FLOOR2;
                end else if (pending[0]) begin
                    below_ok   = 1'b1;
                    below_goal = FLOOR1;
                end
            end
            default: begin
                above_ok = 1'b0;
                below_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        goal     = cur_floor;
        has_goal = 1'b0;
        if (here_ok) begin
            has_goal = 1'b1;
        end else if (dir_up) begin
            if (above_ok) begin
                goal     = above_goal;
                has_goal = 1'b1;
            end else if (below_ok) begin
                goal     = below_goal;
                has_goal = 1'b1;
            end
        end else begin
            if (below_ok) begin
                goal     = below_goal;
                has_goal = 1'b1;
            end else if (above_ok) begin
                goal     = above_goal;
                has_goal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/call_scheduler.sv
// Cabin call scheduler: latches button calls, dispatches SCAN goals to the datapath,
// times door dwell, and halts on SOS, travel timeout or an illegal floor code.
module call_scheduler
    import call_scheduler_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES   = 4,
    parameter int unsigned TRAVEL_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             button_reset,
    input  logic             button1,
    input  logic             button2,
    input  logic             button3,
    input  logic             sos_mode,
    input  logic             weight_limit_exceeded,
    output logic             led1,
    output logic             led2,
    output logic             led3,
    output logic             fault,
    call_scheduler_if.master dp
);

    localparam int unsigned DWELL_W  = $clog2(DWELL_CYCLES + 1);
    localparam int unsigned TRAVEL_W = $clog2(TRAVEL_TIMEOUT + 1);
    localparam logic [DWELL_W-1:0]  DWELL_LOAD   = DWELL_W'(DWELL_CYCLES);
    localparam logic [TRAVEL_W-1:0] TRAVEL_LIMIT = TRAVEL_W'(TRAVEL_TIMEOUT);

    state_e                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] btn_prev_q, btn_prev_d;
    logic [FLOOR_W-1:0]    goal_floor_q, goal_floor_d;
    logic                  goal_valid_q, goal_valid_d;
    logic                  dir_up_q, dir_up_d;
    logic                  door_open_q, door_open_d;
    logic                  fault_q, fault_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic [TRAVEL_W-1:0]   travel_q, travel_d;

    logic [NUM_FLOORS-1:0] buttons_c;
    logic [NUM_FLOORS-1:0] rise_c;
    logic [NUM_FLOORS-1:0] cur_oh_c;
    logic [NUM_FLOORS-1:0] set_mask_c;
    logic [NUM_FLOORS-1:0] clr_mask_c;
    logic [TRAVEL_W-1:0]   travel_inc_c;
    logic                  arrived_c;
    logic                  timeout_c;
    logic                  fault_hit_c;
    logic                  normal_c;
    logic [FLOOR_W-1:0]    sel_goal_c;
    logic                  sel_has_goal_c;

    call_scheduler_scan_select u_scan (
        .pending   (pending_q),
        .cur_floor (dp.cur_floor),
        .dir_up    (dir_up_q),
        .goal      (sel_goal_c),
        .has_goal  (sel_has_goal_c)
    );

    // Edge detection, arrival/timeout qualifiers and the pending-call set.
    always_comb begin
        buttons_c    = {button3, button2, button1};
        rise_c       = buttons_c & ~btn_prev_q;
        btn_prev_d   = buttons_c;
        cur_oh_c     = floor_onehot(dp.cur_floor);
        travel_inc_c = (travel_q == TRAVEL_LIMIT) ? travel_q : travel_q + TRAVEL_W'(1);
        arrived_c    = (state_q == ST_TRAVEL) && (dp.cur_floor == goal_floor_q) && !dp.moving;
        timeout_c    = (state_q == ST_TRAVEL) && (travel_inc_c >= TRAVEL_LIMIT);
        fault_hit_c  = (dp.cur_floor == FLOOR_BAD) || timeout_c;
        normal_c     = !fault_q && !fault_hit_c && !sos_mode;

        set_mask_c = rise_c;
        if (state_q == ST_DWELL) begin
            set_mask_c = rise_c & ~cur_oh_c;
        end
        clr_mask_c = '0;
        if (normal_c && arrived_c) begin
            clr_mask_c = floor_onehot(goal_floor_q);
        end
        pending_d = (pending_q | set_mask_c) & ~clr_mask_c;
    end

    // Next-state and registered-output logic; fault outranks SOS, SOS outranks normal flow.
    always_comb begin
        state_d      = state_q;
        goal_floor_d = goal_floor_q;
        goal_valid_d = goal_valid_q;
        dir_up_d     = dir_up_q;
        door_open_d  = door_open_q;
        fault_d      = fault_q;
        dwell_d      = dwell_q;
        travel_d     = travel_q;

        if (fault_q || fault_hit_c) begin
            fault_d      = 1'b1;
            state_d      = ST_HALT;
            goal_valid_d = 1'b0;
            door_open_d  = 1'b0;
        end else if (sos_mode) begin
            state_d      = ST_HALT;
            goal_valid_d = 1'b0;
            door_open_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    goal_valid_d = 1'b0;
                    door_open_d  = 1'b0;
                    if (|pending_q) begin
                        state_d = ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    if (sel_has_goal_c) begin
                        goal_floor_d = sel_goal_c;
                        goal_valid_d = 1'b1;
                        travel_d     = '0;
                        state_d      = ST_TRAVEL;
                        if (sel_goal_c > dp.cur_floor) begin
                            dir_up_d = 1'b1;
                        end else if (sel_goal_c < dp.cur_floor) begin
                            dir_up_d = 1'b0;
                        end
                    end else begin
                        goal_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end
                ST_TRAVEL: begin
                    travel_d = travel_inc_c;
                    if (arrived_c) begin
                        goal_valid_d = 1'b0;
                        door_open_d  = 1'b1;
                        dwell_d      = DWELL_LOAD;
                        state_d      = ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    door_open_d = 1'b1;
                    // Overload or a fresh press at this floor keeps the door open a full dwell.
                    if (weight_limit_exceeded || |(rise_c & cur_oh_c)) begin
                        dwell_d = DWELL_LOAD;
                    end else if (dwell_q <= DWELL_W'(1)) begin
                        door_open_d = 1'b0;
                        dwell_d     = '0;
                        state_d     = (|pending_d) ? ST_DISPATCH : ST_IDLE;
                    end else begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end
                end
                ST_HALT: begin
                    goal_valid_d = 1'b0;
                    door_open_d  = 1'b0;
                    state_d      = (|pending_q) ? ST_DISPATCH : ST_IDLE;
                end
                default: begin
                    goal_valid_d = 1'b0;
                    door_open_d  = 1'b0;
                    state_d      = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (button_reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            btn_prev_q   <= {button3, button2, button1};
            goal_floor_q <= FLOOR1;
            goal_valid_q <= 1'b0;
            dir_up_q     <= 1'b1;
            door_open_q  <= 1'b0;
            fault_q      <= 1'b0;
            dwell_q      <= '0;
            travel_q     <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            btn_prev_q   <= btn_prev_d;
            goal_floor_q <= goal_floor_d;
            goal_valid_q <= goal_valid_d;
            dir_up_q     <= dir_up_d;
            door_open_q  <= door_open_d;
            fault_q      <= fault_d;
            dwell_q      <= dwell_d;
            travel_q     <= travel_d;
        end
    end

    assign led1          = pending_q[0];
    assign led2          = pending_q[1];
    assign led3          = pending_q[2];
    assign fault         = fault_q;
    assign dp.goal_floor = goal_floor_q;
    assign dp.goal_valid = goal_valid_q;
    assign dp.dir_up     = dir_up_q;
    assign dp.door_open  = door_open_q;

endmodule

// File: tb/tb_call_scheduler.sv
// Scoreboard bench for call_scheduler: the bench plays the movement datapath and predicts
// each dispatched goal/direction from the SCAN rules; a monitor checks every dispatch and dwell.
module tb_call_scheduler;
    import call_scheduler_pkg::*;

    localparam int DWELL = 4;
    localparam int TMO   = 64;
    localparam int WAIT_LIMIT = 300;

    typedef struct packed {
        logic [1:0] goal;
        logic       dir;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic button_reset, button1, button2, button3, sos_mode, weight;
    logic led1, led2, led3, fault;

    call_scheduler_if dp();

    call_scheduler #(.DWELL_CYCLES(DWELL), .TRAVEL_TIMEOUT(TMO)) dut (
        .clk                   (clk),
        .button_reset          (button_reset),
        .button1               (button1),
        .button2               (button2),
        .button3               (button3),
        .sos_mode              (sos_mode),
        .weight_limit_exceeded (weight),
        .led1                  (led1),
        .led2                  (led2),
        .led3                  (led3),
        .fault                 (fault),
        .dp                    (dp)
    );

    int   checks = 0;
    int   errors = 0;
    int   exp_dwell = DWELL;
    exp_t sb_q[$];
    int   plan_q[$];

    // Reference model state: pending calls, car floor, sweep direction.
    logic [2:0] m_pending;
    int         m_cur;
    logic       m_dir;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic int leds();
        return int'({led3, led2, led1});
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return dp.goal_valid;
            1:       return dp.door_open;
            default: return fault;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic level, input string name);
        int n;
        n = 0;
        while (sig(sel) !== level) begin
            if (n == WAIT_LIMIT) begin
                check({name, "_timeout"}, 0, 1);
                return;
            end
            tick();
            n++;
        end
    endtask

    // SCAN: call at the car wins; else nearest in the sweep direction; else nearest the other way.
    function automatic void scan(input logic [2:0] p, input int cur, input logic dir,
                                 output int g, output logic nd);
        int step;
        int f;
        g  = -1;
        nd = dir;
        if (p[cur]) begin
            g = cur;
        end else begin
            for (int pass = 0; pass < 2; pass++) begin
                step = ((pass == 0) == (dir == 1'b1)) ? 1 : -1;
                for (int d = 1; d <= 2; d++) begin
                    f = cur + step * d;
                    if (g < 0 && f >= 0 && f <= 2 && p[f]) g = f;
                end
                if (g >= 0) break;
            end
        end
        if (g > cur) nd = 1'b1;
        else if (g >= 0 && g < cur) nd = 1'b0;
    endfunction

    // Predict the whole dispatch chain that will serve the current pending set.
    task automatic predict();
        logic [2:0] p;
        int   c, g;
        logic d, nd;
        exp_t e;
        p = m_pending;
        c = m_cur;
        d = m_dir;
        plan_q.delete();
        while (p != 3'b000) begin
            scan(p, c, d, g, nd);
            if (g < 0) break;
            e.goal = 2'(g);
            e.dir  = nd;
            sb_q.push_back(e);
            plan_q.push_back(g);
            d    = nd;
            p[g] = 1'b0;
            c    = g;
        end
        m_dir = d;
    endtask

    task automatic press(input logic [2:0] mask);
        {button3, button2, button1} = mask;
        m_pending = m_pending | mask;
        tick();
        {button3, button2, button1} = 3'b000;
        check("leds_after_press", leds(), int'(m_pending));
        predict();
    endtask

    // Datapath role for one dispatch: move, arrive, optionally overload the door.
    task automatic serve_one(input int move, input int wl);
        int g;
        wait_sig(0, 1'b1, "dispatch");
        if (plan_q.size() == 0) begin
            check("plan_underflow", 0, 1);
            return;
        end
        g = plan_q.pop_front();
        exp_dwell = DWELL + wl;
        dp.moving = 1'b1;
        tick(move);
        dp.cur_floor = dp.goal_floor;
        dp.moving    = 1'b0;
        wait_sig(0, 1'b0, "arrive");
        if (wl > 0) begin
            weight = 1'b1;
            tick(wl);
            weight = 1'b0;
        end
        wait_sig(1, 1'b0, "door_close");
        m_cur        = g;
        m_pending[g] = 1'b0;
        check("leds_after_arrival", leds(), int'(m_pending));
    endtask

    task automatic serve_all();
        int wl;
        while (plan_q.size() > 0) begin
            wl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            serve_one(int'($urandom_range(1, 5)), wl);
        end
        tick(3);
        check("idle_after_serve", int'(dp.goal_valid), 0);
    endtask

    task automatic do_reset(input logic [1:0] floor);
        button_reset = 1'b1;
        dp.cur_floor = floor;
        dp.moving    = 1'b0;
        sos_mode     = 1'b0;
        weight       = 1'b0;
        tick(2);
        button_reset = 1'b0;
        m_pending = 3'b000;
        m_cur     = int'(floor);
        m_dir     = 1'b1;
        plan_q.delete();
        tick();
    endtask

    // Monitor: pops the scoreboard on every goal_valid rise and measures each door-open run.
    initial begin : monitor
        logic gv_prev;
        int   door_run;
        exp_t e;
        gv_prev  = 1'b0;
        door_run = 0;
        forever begin
            @(negedge clk);
            if (dp.goal_valid === 1'b1 && !gv_prev) begin
                if (sb_q.size() == 0) begin
                    check("dispatch_expected", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    check("goal_floor", int'(dp.goal_floor), int'(e.goal));
                    check("dir_up", int'(dp.dir_up), int'(e.dir));
                end
            end
            gv_prev = (dp.goal_valid === 1'b1);
            if (dp.door_open === 1'b1) begin
                door_run++;
            end else if (door_run > 0) begin
                check("door_cycles", door_run, exp_dwell);
                door_run = 0;
            end
        end
    end

    initial begin : stimulus
        int   n;
        logic [2:0] mask;
        {button3, button2, button1} = 3'b000;
        do_reset(FLOOR1);
        check("rst_leds", leds(), 0);
        check("rst_goal_floor", int'(dp.goal_floor), 0);
        check("rst_goal_valid", int'(dp.goal_valid), 0);
        check("rst_dir_up", int'(dp.dir_up), 1);
        check("rst_door_open", int'(dp.door_open), 0);
        check("rst_fault", int'(fault), 0);

        // Single call upward from F1.
        press(3'b100);
        serve_all();

        // Reposition to F2 heading up, then calls both sides: F3 first, then F1.
        press(3'b001);
        serve_all();
        press(3'b010);
        serve_all();
        press(3'b101);
        serve_all();

        // Overload held for 10 cycles at F3.
        press(3'b100);
        serve_one(2, 10);
        tick(3);

        // SOS mid-travel, then release re-issues the same goal.
        press(3'b001);
        wait_sig(0, 1'b1, "sos_dispatch");
        dp.moving = 1'b1;
        tick(2);
        sos_mode = 1'b1;
        tick();
        check("sos_goal_valid_drop", int'(dp.goal_valid), 0);
        check("sos_leds_kept", leds(), int'(m_pending));
        tick(2);
        sos_mode  = 1'b0;
        dp.moving = 1'b0;
        predict();
        serve_all();

        // Travel timeout: car never arrives.
        press(3'b010);
        wait_sig(0, 1'b1, "tmo_dispatch");
        void'(plan_q.pop_front());
        dp.moving = 1'b1;
        n = 0;
        while (dp.goal_valid === 1'b1 && n < TMO + 10) begin
            n++;
            tick();
        end
        check("timeout_cycles", n, TMO);
        check("timeout_fault", int'(fault), 1);
        sos_mode = 1'b1;
        tick(2);
        sos_mode = 1'b0;
        tick(3);
        check("fault_sticky", int'(fault), 1);
        check("fault_goal_valid", int'(dp.goal_valid), 0);
        check("fault_door_open", int'(dp.door_open), 0);
        check("fault_leds_kept", leds(), int'(m_pending));
        do_reset(FLOOR3);
        check("post_fault_rst_fault", int'(fault), 0);
        check("post_fault_rst_leds", leds(), 0);
        check("post_fault_rst_dir", int'(dp.dir_up), 1);

        // Press F1 in the arrival cycle, then again during dwell.
        press(3'b001);
        wait_sig(0, 1'b1, "same_cycle_dispatch");
        void'(plan_q.pop_front());
        dp.moving = 1'b1;
        tick(2);
        exp_dwell    = DWELL + 2;
        dp.cur_floor = FLOOR1;
        dp.moving    = 1'b0;
        button1      = 1'b1;
        tick();
        check("clear_wins_led1", int'(led1), 0);
        check("arrival_door_open", int'(dp.door_open), 1);
        button1 = 1'b0;
        tick();
        button1 = 1'b1;
        tick();
        button1 = 1'b0;
        check("dwell_press_not_latched", int'(led1), 0);
        wait_sig(1, 1'b0, "reload_door_close");
        m_pending = 3'b000;
        m_cur     = 0;
        tick(4);
        check("no_redispatch", int'(dp.goal_valid), 0);

        // Randomised call sets from random idle floors.
        for (int it = 0; it < 24; it++) begin
            dp.cur_floor = 2'($urandom_range(0, 2));
            m_cur = int'(dp.cur_floor);
            tick();
            mask = 3'($urandom_range(1, 7));
            press(mask);
            serve_all();
        end

        // Illegal floor code faults from IDLE.
        exp_dwell    = DWELL;
        dp.cur_floor = FLOOR_BAD;
        tick();
        check("illegal_floor_fault", int'(fault), 1);
        check("illegal_floor_goal_valid", int'(dp.goal_valid), 0);
        do_reset(FLOOR1);
        check("final_rst_fault", int'(fault), 0);

        tick(2);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
